// File: rtl/ifmap_win_pkg.sv
// Shared constants and helpers for the IFMap sliding-window buffer.
// Provides pointer/count width derivation and the advance pop clamp.
package ifmap_win_pkg;

    localparam int DEF_DATA_WIDTH = 18;
    localparam int DEF_DEPTH      = 16;
    localparam int DEF_PAR_WRITE  = 1;
    localparam int DEF_STRIDE_W   = 3;

    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int cnt_w(input int depth);
        return ptr_w(depth) + 1;
    endfunction

    // Words removed by one advance: stride 0 acts as 1, never more than stored.
    function automatic int pop_clamp(input int stride, input int count);
        int s;
        s = (stride == 0) ? 1 : stride;
        return (s < count) ? s : count;
    endfunction

endpackage

// File: rtl/win_mem.sv
// Storage array for the window buffer: PAR_WRITE write lanes at
// consecutive wrapped addresses, one asynchronous read port.
// Ports: clk; we/base/wdata (lane 0 at base); raddr/rdata.
module win_mem
    import ifmap_win_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH      = DEF_DEPTH,
    parameter int PAR_WRITE  = DEF_PAR_WRITE,
    parameter int PTR_W      = ptr_w(DEF_DEPTH)
) (
    input  logic                            clk,
    input  logic                            we,
    input  logic [PTR_W-1:0]                base,
    input  logic [PAR_WRITE*DATA_WIDTH-1:0] wdata,
    input  logic [PTR_W-1:0]                raddr,
    output logic [DATA_WIDTH-1:0]           rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // PTR_W-bit address arithmetic wraps modulo DEPTH (power of two).
    always_ff @(posedge clk) begin
        if (we) begin
            for (int l = 0; l < PAR_WRITE; l++) begin
                mem[base + PTR_W'(l)] <= wdata[l*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/ifmap_window_buffer.sv
// Circular IFMap buffer exposing a sliding read window of win_len words.
// Ports: clk, rstn (sync, active-low), clear; wen/din/full/empty/count;
// win_len/stride/advance/win_valid; rd_idx/dout; ovf_err (sticky).
// IFMAP_WIN_REG_OUT_EN: registers dout (1-cycle read latency).
module ifmap_window_buffer
    import ifmap_win_pkg::*;
#(
    parameter int   DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int   DEPTH      = DEF_DEPTH,
    parameter int   PAR_WRITE  = DEF_PAR_WRITE,
    parameter int   STRIDE_W   = DEF_STRIDE_W,
    localparam int  PTR_W      = ptr_w(DEPTH),
    localparam int  CNT_W      = cnt_w(DEPTH)
) (
    input  logic                            clk,
    input  logic                            rstn,
    input  logic                            clear,
    input  logic                            wen,
    input  logic [PAR_WRITE*DATA_WIDTH-1:0] din,
    output logic                            full,
    output logic                            empty,
    output logic [CNT_W-1:0]                count,
    input  logic [CNT_W-1:0]                win_len,
    input  logic [STRIDE_W-1:0]             stride,
    input  logic                            advance,
    input  logic [PTR_W-1:0]                rd_idx,
    output logic [DATA_WIDTH-1:0]           dout,
    output logic                            win_valid,
    output logic                            ovf_err
);

    localparam logic [CNT_W-1:0] FULL_TH = CNT_W'(DEPTH - PAR_WRITE);
    localparam logic [CNT_W-1:0] PW_CNT  = CNT_W'(PAR_WRITE);

    logic [PTR_W-1:0]      rp;
    logic [PTR_W-1:0]      wp;
    logic [CNT_W-1:0]      pop;
    logic [CNT_W-1:0]      count_next;
    logic                  wr;
    logic                  adv;
    logic                  rd_hit;
    logic [DATA_WIDTH-1:0] rdata;
    logic [DATA_WIDTH-1:0] rd_word;

    assign full      = count > FULL_TH;
    assign empty     = count == '0;
    assign win_valid = (win_len != '0) && (count >= win_len);

    // Write acceptance uses the pre-advance count; freed space is
    // only usable from the next cycle.
    assign wr  = wen && !full;
    assign adv = advance && win_valid;
    assign pop = CNT_W'(pop_clamp(int'(stride), int'(count)));

    always_comb begin
        count_next = count;
        if (wr) begin
            count_next = count_next + PW_CNT;
        end
        if (adv) begin
            count_next = count_next - pop;
        end
    end

    // pop may equal DEPTH; truncation to PTR_W keeps rp modulo DEPTH.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            rp      <= '0;
            wp      <= '0;
            count   <= '0;
            ovf_err <= 1'b0;
        end else if (clear) begin
            rp    <= '0;
            wp    <= '0;
            count <= '0;
        end else begin
            if (wr) begin
                wp <= wp + PTR_W'(PAR_WRITE);
            end
            if (adv) begin
                rp <= rp + pop[PTR_W-1:0];
            end
            if (wen && full) begin
                ovf_err <= 1'b1;
            end
            count <= count_next;
        end
    end

    win_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .PAR_WRITE  (PAR_WRITE),
        .PTR_W      (PTR_W)
    ) u_mem (
        .clk   (clk),
        .we    (wr && rstn && !clear),
        .base  (wp),
        .wdata (din),
        .raddr (rp + rd_idx),
        .rdata (rdata)
    );

    assign rd_hit  = (CNT_W'(rd_idx) < count) && (CNT_W'(rd_idx) < win_len);
    assign rd_word = rd_hit ? rdata : '0;

`ifdef IFMAP_WIN_REG_OUT_EN
    logic [DATA_WIDTH-1:0] dout_q;

    always_ff @(posedge clk) begin
        if (!rstn || clear) begin
            dout_q <= '0;
        end else begin
            dout_q <= rd_word;
        end
    end

    assign dout = dout_q;
`else
    assign dout = rd_word;
`endif

endmodule
